// File: rtl/cntr_ctrl.sv
// Wishbone-programmed pad counter with prescaler, one-shot/auto-reload, compare and IRQ; CNTR_CTRL_GRAY_EN adds CTRL[6] Gray-coded pad output.
// Latency: ack 1 cycle after request, write commits at end of ack cycle; cnt_o follows count directly, irq_o 1 cycle after flag.
// Backpressure: none; at most one request per two cycles since nothing is accepted while ack is high.
module cntr_ctrl #(
   parameter int          BITS      = 20,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [BITS-1:0] cnt_o,
   output logic [BITS-1:0] cnt_oeb_o,
   output logic            irq_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
   state_t state, state_nxt;

   logic            en, dir, irq_en, oe, gray;
   logic [1:0]      mode;
   logic [BITS-1:0] load, cmp, count;
   logic [15:0]     presc, psc_cnt;
   logic            match, done;

   logic            hit, req, wr;
   logic            wr_ctrl, wr_load, wr_presc, wr_cmp, wr_count, wr_status;
   logic [5:0]      reg_sel;
   logic [31:0]     wmask, rdata;
   logic [BITS-1:0] msk_b, dat_b;

   logic [BITS-1:0] term, start, stepped, cnt_tick;
   logic            at_term, wrap_hit, tick, tick_eff, entering;
   logic            match_set, done_set, os_done;
   logic            unused_ok;

   function automatic logic [BITS-1:0] merge(input logic [BITS-1:0] old,
                                             input logic [BITS-1:0] dat,
                                             input logic [BITS-1:0] msk);
      return (old & ~msk) | (dat & msk);
   endfunction

   assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req     = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
   // Classic Wishbone holds the request through ack, so the write lands at the end of the ack cycle.
   assign wr      = wbs_ack_o & wbs_stb_i & wbs_cyc_i & wbs_we_i & hit;
   assign reg_sel = wbs_adr_i[7:2];

   assign wr_ctrl   = wr && (reg_sel == 6'h00);
   assign wr_load   = wr && (reg_sel == 6'h01);
   assign wr_presc  = wr && (reg_sel == 6'h02);
   assign wr_cmp    = wr && (reg_sel == 6'h03);
   assign wr_count  = wr && (reg_sel == 6'h04);
   assign wr_status = wr && (reg_sel == 6'h05);

   assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign msk_b = wmask[BITS-1:0];
   assign dat_b = wbs_dat_i[BITS-1:0];

   always_comb begin
      rdata = '0;
      case (reg_sel)
         6'h00:   rdata = {25'd0, gray, oe, irq_en, mode, dir, en};
         6'h01:   rdata = 32'(load);
         6'h02:   rdata = {16'd0, presc};
         6'h03:   rdata = 32'(cmp);
         6'h04:   rdata = 32'(count);
         6'h05:   rdata = {29'd0, state == ST_RUN, done, match};
         default: rdata = '0;
      endcase
   end

   assign term     = dir ? '0 : load;
   assign start    = dir ? load : '0;
   assign at_term  = (count == term);
   assign stepped  = dir ? count - 1'b1 : count + 1'b1;
   assign tick     = (state == ST_RUN) && en && (psc_cnt == presc);
   assign tick_eff = tick && !wr_count;
   assign entering = (state != ST_RUN) && (state_nxt == ST_RUN);

   // One-shot parks on terminal (covers LOAD=0 finishing on the first tick); auto-reload restarts one tick later.
   always_comb begin
      cnt_tick = stepped;
      wrap_hit = 1'b0;
      if (mode == 2'b01) begin
         cnt_tick = at_term ? count : stepped;
         wrap_hit = at_term || (stepped == term);
      end else if (mode == 2'b10) begin
         cnt_tick = at_term ? start : stepped;
         wrap_hit = at_term;
      end
   end

   assign match_set = tick_eff && (cnt_tick == cmp);
   assign done_set  = tick_eff && wrap_hit;
   assign os_done   = done_set && (mode == 2'b01);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (en) state_nxt = ST_RUN;
         ST_RUN: begin
            if (!en)          state_nxt = ST_IDLE;
            else if (os_done) state_nxt = ST_DONE;
         end
         ST_DONE: if (en) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state     <= ST_IDLE;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         en        <= 1'b0;
         dir       <= 1'b0;
         mode      <= 2'b00;
         irq_en    <= 1'b0;
         oe        <= 1'b0;
         load      <= '0;
         presc     <= '0;
         cmp       <= '0;
         count     <= '0;
         psc_cnt   <= '0;
         match     <= 1'b0;
         done      <= 1'b0;
         irq_o     <= 1'b0;
      end else begin
         state     <= state_nxt;
         wbs_ack_o <= req;
         wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;

         if (wr_ctrl && wbs_sel_i[0]) begin
            en     <= wbs_dat_i[0];
            dir    <= wbs_dat_i[1];
            mode   <= wbs_dat_i[3:2];
            irq_en <= wbs_dat_i[4];
            oe     <= wbs_dat_i[5];
         end else if (os_done) begin
            en <= 1'b0;
         end

         if (wr_load) load <= merge(load, dat_b, msk_b);
         if (wr_cmp)  cmp  <= merge(cmp, dat_b, msk_b);
         if (wr_presc) begin
            if (wbs_sel_i[0]) presc[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) presc[15:8] <= wbs_dat_i[15:8];
         end

         if (wr_presc || entering || tick) psc_cnt <= '0;
         else if (state == ST_RUN && en)   psc_cnt <= psc_cnt + 16'd1;

         if (wr_count)
            count <= merge(count, dat_b, msk_b);
         else if (entering && (mode == 2'b01 || mode == 2'b10) && at_term)
            count <= start;
         else if (tick_eff)
            count <= cnt_tick;

         match <= match_set | (match & ~(wr_status & wbs_sel_i[0] & wbs_dat_i[0]));
         done  <= done_set  | (done  & ~(wr_status & wbs_sel_i[0] & wbs_dat_i[1]));
         irq_o <= irq_en & (match | done);
      end
   end

`ifdef CNTR_CTRL_GRAY_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)                   gray <= 1'b0;
      else if (wr_ctrl && wbs_sel_i[0]) gray <= wbs_dat_i[6];
   end
   assign cnt_o = gray ? (count ^ (count >> 1)) : count;
`else
   assign gray  = 1'b0;
   assign cnt_o = count;
`endif

   assign cnt_oeb_o = oe ? '0 : '1;
   assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i, wmask};

endmodule

// File: tb/tb_cntr_ctrl.sv
// Bench for cntr_ctrl: Wishbone driver, expected values queued at stimulus time and popped when the DUT answers.
`timescale 1ns/1ps
module tb_cntr_ctrl;
   localparam int          BITS = 20;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] A_CTRL   = BASE + 32'h00;
   localparam logic [31:0] A_LOAD   = BASE + 32'h04;
   localparam logic [31:0] A_PRESC  = BASE + 32'h08;
   localparam logic [31:0] A_CMP    = BASE + 32'h0C;
   localparam logic [31:0] A_COUNT  = BASE + 32'h10;
   localparam logic [31:0] A_STATUS = BASE + 32'h14;

   logic            wb_clk_i = 1'b0;
   logic            wb_rst_ni;
   logic            wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]      wbs_sel_i;
   logic [31:0]     wbs_adr_i, wbs_dat_i;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic [BITS-1:0] cnt_o, cnt_oeb_o;
   logic            irq_o;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] exp_q[$];

   always #5 wb_clk_i = ~wb_clk_i;

   cntr_ctrl #(.BITS(BITS), .BASE_ADDR(BASE)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .cnt_o     (cnt_o),
      .cnt_oeb_o (cnt_oeb_o),
      .irq_o     (irq_o)
   );

   // Called 1ns after a rising edge; returns 1ns after the edge that ends the ack cycle.
   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd);
      int k;
      wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      rd = '0;
      k = 0;
      do begin
         @(posedge wb_clk_i); #1; k++;
      end while (!wbs_ack_o && k < 8);
      if (!wbs_ack_o) begin
         n_chk++;
         $display("FAIL ack_timeout adr=%h: no ack in %0d cycles, ack required", adr, k);
      end else begin
         rd = wbs_dat_o;
      end
      @(posedge wb_clk_i); #1;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(adr, 1'b1, dat, sel, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
      wb_xfer(adr, 1'b0, 32'h0, 4'hF, rd);
   endtask

   task automatic wait_change(output logic [BITS-1:0] v, output int cyc);
      logic [BITS-1:0] prev;
      prev = cnt_o;
      cyc  = 0;
      do begin
         @(posedge wb_clk_i); #1; cyc++;
      end while (cnt_o === prev && cyc < 200);
      v = cnt_o;
      if (cnt_o === prev) begin
         n_chk++;
         $display("FAIL cnt_timeout: cnt_o stuck at %h for %0d cycles, change required", prev, cyc);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd, e;
      logic        seen;
      wb_rst_ni = 1'b0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;
      wbs_adr_i = A_CTRL; wbs_dat_i = 32'h21; wbs_sel_i = 4'hF; wbs_we_i = 1'b1;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      @(posedge wb_clk_i); #1;
      n_chk++;
      if (wbs_ack_o !== 1'b1) $display("FAIL ack_first_cycle got %b need 1", wbs_ack_o);
      else n_pass++;
      wb_rst_ni = 1'b0;
      #1;
      n_chk++;
      if (wbs_ack_o !== 1'b0) $display("FAIL ack_drop_on_reset got %b need 0", wbs_ack_o);
      else n_pass++;
      @(posedge wb_clk_i); @(posedge wb_clk_i); #1;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wb_rst_ni = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL ack_after_release got %b need 0", seen);
      else n_pass++;
      n_chk++;
      if (cnt_oeb_o !== 20'hFFFFF) $display("FAIL reset_oeb got %h need fffff", cnt_oeb_o);
      else n_pass++;
      n_chk++;
      if (irq_o !== 1'b0 || cnt_o !== '0) $display("FAIL reset_irq_cnt got irq=%b cnt=%h need 0/0", irq_o, cnt_o);
      else n_pass++;
      for (int i = 0; i < 7; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 7; i++) begin
         wb_read(BASE + 32'(i * 4), rd);
         e = exp_q.pop_front();
         n_chk++;
         if (rd !== e) $display("FAIL reset_reg_%0d got %h need %h", i, rd, e);
         else n_pass++;
      end
   endtask

   task automatic test_byte_sel();
      logic [31:0] rd, e;
      exp_q.push_back(32'h0000CC00);
      wb_write(A_LOAD, 32'hAABBCCDD, 4'b0010);
      wb_read(A_LOAD, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL byte_sel_load got %h need %h", rd, e);
      else n_pass++;
`ifdef CNTR_CTRL_GRAY_EN
      exp_q.push_back(32'h40);
`else
      exp_q.push_back(32'h0);
`endif
      wb_write(A_CTRL, 32'h40, 4'hF);
      wb_read(A_CTRL, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL ctrl_gray_bit got %h need %h", rd, e);
      else n_pass++;
      wb_write(A_CTRL, 32'h0, 4'hF);
      wb_write(BASE + 32'h1C, 32'h1234, 4'hF);
   endtask

   task automatic test_free_run();
      logic [BITS-1:0] v;
      logic [31:0]     e;
      int              cyc;
      wb_write(A_PRESC, 32'd3, 4'hF);
      wb_write(A_COUNT, 32'h10, 4'hF);
      wb_write(A_CTRL, 32'h21, 4'hF);
      n_chk++;
      if (cnt_oeb_o !== '0) $display("FAIL oe_on got %h need 00000", cnt_oeb_o);
      else n_pass++;
      for (int i = 1; i <= 3; i++) exp_q.push_back(32'h10 + 32'(i));
      for (int i = 0; i < 3; i++) begin
         wait_change(v, cyc);
         e = exp_q.pop_front();
         n_chk++;
         if (32'(v) !== e) $display("FAIL free_run_val got %h need %h", v, e);
         else n_pass++;
         if (i > 0) begin
            n_chk++;
            if (cyc !== 4) $display("FAIL free_run_period got %0d need 4", cyc);
            else n_pass++;
         end
      end
      wb_write(A_CTRL, 32'h20, 4'hF);
      wb_write(A_COUNT, 32'hFFFFF, 4'hF);
      wb_write(A_CTRL, 32'h21, 4'hF);
      exp_q.push_back(32'h0);
      wait_change(v, cyc);
      e = exp_q.pop_front();
      n_chk++;
      if (32'(v) !== e) $display("FAIL free_run_wrap got %h need %h", v, e);
      else n_pass++;
      wb_write(A_CTRL, 32'h20, 4'hF);
   endtask

   task automatic test_one_shot();
      logic [BITS-1:0] v;
      logic [31:0]     e, rd;
      int              cyc;
      wb_write(A_CMP, 32'h100, 4'hF);
      wb_write(A_PRESC, 32'd0, 4'hF);
      wb_write(A_LOAD, 32'd5, 4'hF);
      wb_write(A_COUNT, 32'd0, 4'hF);
      wb_write(A_STATUS, 32'h3, 4'hF);
      wb_write(A_CTRL, 32'h17, 4'hF);
      for (int i = 5; i >= 0; i--) exp_q.push_back(32'(i));
      for (int i = 0; i < 6; i++) begin
         wait_change(v, cyc);
         e = exp_q.pop_front();
         n_chk++;
         if (32'(v) !== e) $display("FAIL one_shot_val got %h need %h", v, e);
         else n_pass++;
      end
      n_chk++;
      if (irq_o !== 1'b0) $display("FAIL irq_same_cycle got %b need 0", irq_o);
      else n_pass++;
      @(posedge wb_clk_i); #1;
      n_chk++;
      if (irq_o !== 1'b1) $display("FAIL irq_next_cycle got %b need 1", irq_o);
      else n_pass++;
      repeat (4) @(posedge wb_clk_i);
      #1;
      n_chk++;
      if (cnt_o !== '0) $display("FAIL one_shot_hold got %h need 00000", cnt_o);
      else n_pass++;
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h16);
      wb_read(A_STATUS, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL one_shot_status got %h need %h", rd, e);
      else n_pass++;
      wb_read(A_CTRL, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL one_shot_ctrl got %h need %h", rd, e);
      else n_pass++;
      wb_write(A_STATUS, 32'h2, 4'hF);
      @(posedge wb_clk_i); #1;
      n_chk++;
      if (irq_o !== 1'b0) $display("FAIL irq_clear got %b need 0", irq_o);
      else n_pass++;
   endtask

   task automatic test_auto_reload();
      logic [BITS-1:0] v;
      logic [31:0]     e, rd;
      int              cyc;
      wb_write(A_PRESC, 32'd15, 4'hF);
      wb_write(A_LOAD, 32'd3, 4'hF);
      wb_write(A_STATUS, 32'h3, 4'hF);
      wb_write(A_CTRL, 32'h09, 4'hF);
      for (int r = 0; r < 2; r++)
         for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i % 4));
      for (int i = 0; i < 8; i++) begin
         wait_change(v, cyc);
         e = exp_q.pop_front();
         n_chk++;
         if (32'(v) !== e) $display("FAIL auto_reload_val got %h need %h", v, e);
         else n_pass++;
         if (e == 32'd3 || e == 32'd0) begin
            wb_read(A_STATUS, rd);
            n_chk++;
            if (rd !== ((e == 32'd0) ? 32'h6 : 32'h4))
               $display("FAIL auto_reload_status at cnt=%h got %h need %h", e, rd, (e == 32'd0) ? 32'h6 : 32'h4);
            else n_pass++;
            if (e == 32'd0) wb_write(A_STATUS, 32'h2, 4'hF);
         end
      end
      wb_write(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_priority();
      logic [BITS-1:0] v;
      logic [31:0]     e, rd;
      int              cyc;
      wb_write(A_PRESC, 32'd9, 4'hF);
      wb_write(A_CMP, 32'd7, 4'hF);
      wb_write(A_COUNT, 32'd5, 4'hF);
      wb_write(A_STATUS, 32'h3, 4'hF);
      wb_write(A_CTRL, 32'h21, 4'hF);
      wait_change(v, cyc);
      n_chk++;
      if (v !== 20'd6) $display("FAIL prio_sync got %h need 00006", v);
      else n_pass++;
      // Next tick (6->7) is 10 edges away; the write commits on the edge after its ack.
      repeat (8) @(posedge wb_clk_i);
      #1;
      wb_write(A_COUNT, 32'h10, 4'hF);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h4);
      wb_read(A_COUNT, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL count_write_wins got %h need %h", rd, e);
      else n_pass++;
      wb_read(A_STATUS, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL match_dropped_tick got %h need %h", rd, e);
      else n_pass++;
      wb_write(A_COUNT, 32'd5, 4'hF);
      wait_change(v, cyc);
      n_chk++;
      if (v !== 20'd6) $display("FAIL prio_resync got %h need 00006", v);
      else n_pass++;
      repeat (8) @(posedge wb_clk_i);
      #1;
      wb_write(A_STATUS, 32'h1, 4'hF);
      exp_q.push_back(32'h5);
      wb_read(A_STATUS, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) $display("FAIL match_set_beats_w1c got %h need %h", rd, e);
      else n_pass++;
      wb_write(A_CTRL, 32'h0, 4'hF);
   endtask

   initial begin
      test_reset();
      test_byte_sel();
      test_free_run();
      test_one_shot();
      test_auto_reload();
      test_priority();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cntr_ctrl.md
Name: cntr_ctrl

Overview:
- Wishbone-programmable controller that sequences the 20-bit pad counter in the user project area.
- Provides enable, direction, mode, prescaler, reload, compare and IRQ generation.
- Drives the count onto io_out[BITS-1:0] and its output enables onto io_oeb[BITS-1:0].
- Instantiated in user_project_wrapper. The wrapper feeds it the inverted wb_rst_i and connects irq_o to user_irq[0].

Parameters:
- BITS, 20, counter and pad width (1..32).
- BASE_ADDR, 32'h3000_0000, Wishbone base; a request decodes when wbs_adr_i[31:8] == BASE_ADDR[31:8].

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  reset; asynchronous assert, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; honoured per byte on writes.
- wbs_adr_i  in  32  byte address; register = adr[7:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- cnt_o  out  BITS  count value to io_out.
- cnt_oeb_o  out  BITS  pad output enables (active-low) to io_oeb.
- irq_o  out  1  level interrupt.

Behaviour:
- Registers (unused bits read 0; undecoded offsets read 0, writes ignored, still acked):
  - 0x00 CTRL: [0] EN, [1] DIR (0 up / 1 down), [3:2] MODE (00 free-run, 01 one-shot, 10 auto-reload, 11 treated as 00), [4] IRQ_EN, [5] OE.
  - 0x04 LOAD [BITS-1:0].
  - 0x08 PRESC [15:0].
  - 0x0C CMP [BITS-1:0].
  - 0x10 COUNT [BITS-1:0]: read returns live count; write forces count.
  - 0x14 STATUS: [0] MATCH (W1C), [1] DONE (W1C), [2] RUNNING (RO).
- Reset values: all registers 0, state IDLE, wbs_ack_o=0, wbs_dat_o=0, cnt_o=0, cnt_oeb_o=all 1s, irq_o=0.
- Wishbone handshake:
  - ack asserts the cycle after stb&cyc are sampled and lasts exactly 1 cycle.
  - No new request is accepted in the ack cycle, so there is never a double ack.
  - Read data is valid with ack.
  - Write effects are visible from the cycle after ack.
- Prescaler:
  - tick fires every PRESC+1 cycles while in RUN.
  - The prescaler counter clears on entry to RUN and on any PRESC write.
- Terminal value: up counts reach LOAD; down counts reach 0. Start value: 0 for up, LOAD for down.
- FSM states:
  - IDLE: entered on reset or EN=0. Count holds. EN 0->1 goes to RUN.
  - RUN: count +/-1 per tick, modulo 2^BITS.
    - Free-run: wraps and never stops.
    - One-shot: the tick that lands on terminal sets DONE, clears EN, and goes to DONE.
    - Auto-reload: the tick after terminal is reached loads the start value and sets DONE.
  - DONE: count holds. A write of EN=1 goes to RUN.
- Entering RUN in one-shot or auto-reload mode with count == terminal loads the start value first.
- MATCH flag sets on any tick that produces count == CMP.
- Priority and boundary rules:
  - A COUNT write in the same cycle as a tick: the write wins, and that tick is dropped.
  - A W1C in the same cycle as a flag set: the set wins.
  - EN cleared mid-run: go to IDLE immediately; count and flags are kept.
  - Reset mid-transfer: ack drops immediately, and no register is written.
  - LOAD=0 in down/one-shot mode: completes on the first tick.
- Outputs:
  - cnt_o follows count with no added latency.
  - cnt_oeb_o = OE ? 0 : all 1s.
  - irq_o = IRQ_EN & (MATCH | DONE), registered (1 cycle after the flag sets).
- RUNNING = (state == RUN).

Optional Feature:
- Macro: CNTR_CTRL_GRAY_EN.
- Defined:
  - CTRL[6] GRAY becomes writable.
  - When GRAY=1, cnt_o = count ^ (count >> 1).
  - The COUNT register still reads binary.
- Undefined: CTRL[6] reads 0, writes are ignored, and cnt_o is always binary.

Test Plan:
- Reset with wb_rst_ni=0 mid-write -> all registers read 0, cnt_oeb_o=20'hFFFFF, irq_o=0, no ack after release.
- Up-count in free-run: PRESC=3, CTRL=0x21 -> cnt_o increments every 4 cycles; from COUNT=20'hFFFFF the next tick gives 0.
- Down one-shot: LOAD=5, PRESC=0, CTRL=0x17 -> cnt_o 5,4,3,2,1,0 on consecutive ticks, then holds at 0. STATUS=0x2, CTRL[0]=0, irq_o=1 one cycle after DONE sets. Writing STATUS=0x2 clears irq_o.
- Auto-reload up: LOAD=3, CTRL=0x09 -> sequence 0,1,2,3,0,1… with DONE set at each 3->0 reload.
- Compare and priority: CMP=7 with a COUNT write of 0x10 on the same cycle as the tick -> COUNT reads 0x10 and MATCH stays clear. Then W1C of MATCH in the same cycle as a new match -> MATCH remains 1.
- Byte select: write 0xAABBCCDD to LOAD with sel=4'b0010 -> LOAD reads 0x0000CC00.
